boot_loader: RTL and testbench
==============================

# boot_loader

Boot-time program loader and processor reset sequencer for the five-stage pipeline. It accepts a valid/ready stream of instruction words from a host or test source and writes them into instruction memory from address 0. It holds the processor's reset through the load and a programmable settle window, then releases it. It is the driving end of the processor's `clk`/`reset` interface and replaces ad-hoc reset and initialization sequencing in benches and top level.

## Interface
Parameters:
- `DATA_WIDTH`, 16: instruction word width.
- `ADDR_WIDTH`, 11: instruction memory address width. Capacity is 2^ADDR_WIDTH words.
- `HOLD_CYCLES`, 4: cycles `cpu_reset` stays high after the last word is written. Must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `reboot`, in, 1: request a new load. Honoured only in RUN or ERROR.
- `src_valid`, in, 1: source word valid.
- `src_data`, in, DATA_WIDTH: instruction word.
- `src_last`, in, 1: marks the final word of the image; qualified by `src_valid`.
- `src_ready`, out, 1: loader can accept a word.
- `imem_we`, out, 1: instruction memory write strobe.
- `imem_addr`, out, ADDR_WIDTH: write address.
- `imem_data`, out, DATA_WIDTH: write data.
- `cpu_reset`, out, 1: reset to the Processor, active-high.
- `boot_done`, out, 1: high in RUN.
- `err`, out, 1: image overflow flag; high in ERROR.
- `words_loaded`, out, ADDR_WIDTH+1: number of words accepted in the current load.

## Operation
- FSM states are IDLE, LOAD, HOLD, RUN and ERROR. Reset puts the FSM in IDLE.
- IDLE → LOAD unconditionally on the next edge.
- Accept rule: a word is accepted on any edge where `src_valid && src_ready`.
- `src_ready` is a decode of the state register: 1 only in LOAD. It is never a function of `src_valid`.
- LOAD, accept without `src_last`:
  - The word is written at the address counter.
  - The counter increments and `words_loaded` increments.
- LOAD, accept with `src_last`: the word is written and the FSM goes to HOLD. The hold counter loads HOLD_CYCLES.
- Overflow: an accept without `src_last` while the counter equals 2^ADDR_WIDTH−1 still writes that word, then the FSM goes to ERROR. The counter does not wrap.
- An accept with `src_last` at address 2^ADDR_WIDTH−1 is legal and goes to HOLD.
- HOLD:
  - The hold counter decrements every cycle.
  - At 1, the FSM goes to RUN on the next edge.
  - `src_valid` is ignored.
- RUN: `cpu_reset` = 0 and `boot_done` = 1.
- ERROR: `cpu_reset` = 1, `err` = 1, `src_ready` = 0.
- `reboot` in RUN or ERROR:
  - The FSM goes to LOAD.
  - The address counter and `words_loaded` clear.
  - `err` and `boot_done` clear.
  - `cpu_reset` is 1 from the same edge.
- `reboot` in IDLE, LOAD or HOLD is ignored.
- `words_loaded` width ADDR_WIDTH+1 holds the full-capacity count 2^ADDR_WIDTH without overflow.

## Timing
- Reset values: `cpu_reset` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_data` = 0, `boot_done` = 0, `err` = 0, `words_loaded` = 0, `src_ready` = 0 (FSM in IDLE).
- `src_ready` first rises one edge after `reset` deasserts.
- Write latency is 1 cycle. A word accepted at edge N appears at edge N as registered `imem_we` = 1 with `imem_addr` and `imem_data`, valid during cycle N..N+1. `imem_we` is a one-cycle pulse per accepted word.
- Back-to-back accepts are allowed: one word per cycle sustained.
- Release: `cpu_reset` falls exactly HOLD_CYCLES+1 edges after the edge that accepted the last word. The last memory write is therefore retired before release.
- `cpu_reset`, `boot_done` and `err` are registered, so they are glitch-free.
- `reset` mid-load:
  - All outputs take their reset values immediately (asynchronous).
  - The partial image is abandoned and the next load restarts at address 0.
  - Memory contents are not cleared.
- Simultaneous `reboot` and `reset`: `reset` wins.

## Structure
- A shared package `boot_pkg` holds:
  - the state enum constants (IDLE, LOAD, HOLD, RUN, ERROR);
  - the default DATA_WIDTH and ADDR_WIDTH, which match the instruction memory.
- One sub-module is natural: `reset_hold_counter`. It is a loadable down-counter with `load`, `value` and `zero` signals, reused for HOLD timing.
- The address counter and FSM stay in `boot_loader`.

## Test plan
- Reset, then 3 words 0x1111, 0x2222, 0x3333 with last on the third, `src_valid` held high → writes at addr 0, 1, 2 on consecutive edges. `words_loaded` = 3. With HOLD_CYCLES = 4, `cpu_reset` falls 5 edges after the third accept and `boot_done` rises.
- Source stalls: `src_valid` toggles 1,0,0,1,1 with last on the final word → exactly 3 `imem_we` pulses with no gaps in address; addr 0..2.
- Overflow with ADDR_WIDTH = 2: 5 words, no last → 4 writes at addr 0..3. `err` = 1 after the 4th accept. `src_ready` = 0 and `cpu_reset` = 1 thereafter. `reboot` → LOAD, addr restarts at 0, `err` = 0.
- Exact fit with ADDR_WIDTH = 2: 4 words, last on the 4th → HOLD then RUN, `err` = 0, `words_loaded` = 4.
- Asynchronous `reset` pulse after 2 of 5 words → `cpu_reset` = 1 and `src_ready` = 0 immediately. A reload of 2 words writes at addr 0, 1.
- `reboot` asserted during LOAD and during HOLD → ignored, and release timing is unchanged. `reboot` in RUN → `cpu_reset` = 1 on the same edge and `boot_done` = 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: default memory geometry matching the
// instruction memory, and the loader FSM state encoding.
package boot_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddrWidth = 11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHold,
    StRun,
    StError
  } boot_state_e;

endpackage

// File: rtl/reset_hold_counter.sv
// Loadable down-counter used to time the reset settle window.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset (clears the count)
//   load_i       : load load_value_i (takes priority over dec_i)
//   load_value_i : value to load
//   dec_i        : decrement by one; saturates at zero
//   value_o      : current count
//   zero_o       : count is zero
module reset_hold_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             dec_i,
  output logic [Width-1:0] value_o,
  output logic             zero_o
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_value_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/boot_loader.sv
// Boot-time program loader and processor reset sequencer. Streams instruction
// words into instruction memory from address 0, holds the processor in reset
// through the load plus a settle window, then releases it.
//   clk, reset          : clock and asynchronous active-high reset
//   reboot              : request a new load (honoured in RUN or ERROR only)
//   src_valid/data/last : instruction word stream; src_ready accepts it
//   imem_we/addr/data   : registered instruction memory write port
//   cpu_reset           : processor reset, active-high, registered
//   boot_done           : processor running
//   err                 : image overflowed memory capacity
//   words_loaded        : words accepted in the current load
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reboot,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_last,
  output logic                  src_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_data,
  output logic                  cpu_reset,
  output logic                  boot_done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned HoldWidth = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldWidth-1:0] HoldInit = HoldWidth'(HOLD_CYCLES);
  localparam logic [HoldWidth-1:0] HoldOne  = HoldWidth'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

  boot_state_e state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [ADDR_WIDTH:0]   words_d, words_q;
  logic                  imem_we_d, imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_d, imem_addr_q;
  logic [DATA_WIDTH-1:0] imem_data_d, imem_data_q;
  logic                  cpu_reset_d, cpu_reset_q;
  logic                  boot_done_d, boot_done_q;
  logic                  err_d, err_q;

  logic                  accept;
  logic                  hold_load;
  logic [HoldWidth-1:0]  hold_value;
  logic                  hold_zero;

  assign src_ready = (state_q == StLoad);
  assign accept    = src_valid && src_ready;

  reset_hold_counter #(
    .Width (HoldWidth)
  ) u_hold_cnt (
    .clk          (clk),
    .reset        (reset),
    .load_i       (hold_load),
    .load_value_i (HoldInit),
    .dec_i        (state_q == StHold),
    .value_o      (hold_value),
    .zero_o       (hold_zero)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    hold_load = 1'b0;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        if (accept) begin
          words_d = words_q + 1'b1;
          if (src_last) begin
            state_d   = StHold;
            hold_load = 1'b1;
          end else if (addr_q == AddrMax) begin
            // Word at the top address is still written; the counter never wraps.
            state_d = StError;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      // hold_zero only guards against a stuck counter; normal exit is at one.
      StHold: if ((hold_value == HoldOne) || hold_zero) state_d = StRun;
      StRun, StError: begin
        if (reboot) begin
          state_d = StLoad;
          addr_d  = '0;
          words_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_we_d   = accept;
    imem_addr_d = accept ? addr_q : imem_addr_q;
    imem_data_d = accept ? src_data : imem_data_q;
    // Release is registered off the RUN state so it lands one edge after entry,
    // while a reboot re-asserts reset on the very edge it is sampled.
    cpu_reset_d = !((state_q == StRun) && !reboot);
    boot_done_d = (state_q == StRun) && !reboot;
    err_d       = (state_d == StError);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      words_q     <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      cpu_reset_q <= 1'b1;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      cpu_reset_q <= cpu_reset_d;
      boot_done_q <= boot_done_d;
      err_q       <= err_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_data    = imem_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign boot_done    = boot_done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          reboot;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          src_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          cpu_reset;
  logic          boot_done;
  logic          err;
  logic [AW:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  boot_loader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reboot       (reboot),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .cpu_reset    (cpu_reset),
    .boot_done    (boot_done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic          vpat[5];
  logic [DW-1:0] dpat[5];
  int            apat[5];

  initial begin
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dpat = '{16'h4444, 16'hdead, 16'hbeef, 16'h5555, 16'h6666};
    apat = '{0, 0, 0, 1, 2};

    reset     = 1'b1;
    reboot    = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    src_last  = 1'b0;
    tick();
    tick();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_data", imem_data, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_ready", src_ready, 0);

    // Basic 3-word load, valid held high.
    reset     = 1'b0;
    src_valid = 1'b1;
    src_data  = 16'h1111;
    tick();
    chk("idle_to_load_ready", src_ready, 1);
    chk("idle_no_write", imem_we, 0);
    tick();
    chk("w0_we", imem_we, 1);
    chk("w0_addr", imem_addr, 0);
    chk("w0_data", imem_data, 16'h1111);
    src_data = 16'h2222;
    tick();
    chk("w1_addr", imem_addr, 1);
    chk("w1_data", imem_data, 16'h2222);
    src_data = 16'h3333;
    src_last = 1'b1;
    tick();
    chk("w2_we", imem_we, 1);
    chk("w2_addr", imem_addr, 2);
    chk("w2_data", imem_data, 16'h3333);
    chk("w2_words", words_loaded, 3);
    chk("hold_ready", src_ready, 0);
    src_valid = 1'b0;
    src_last  = 1'b0;
    for (int i = 1; i <= HC; i++) begin
      tick();
      chk("hold_cpu_reset", cpu_reset, 1);
      chk("hold_boot_done", boot_done, 0);
    end
    chk("hold_we_idle", imem_we, 0);
    tick();
    chk("release_cpu_reset", cpu_reset, 0);
    chk("release_boot_done", boot_done, 1);

    // Reboot from RUN: reset reasserts on the same edge.
    reboot = 1'b1;
    tick();
    reboot = 1'b0;
    chk("reboot_cpu_reset", cpu_reset, 1);
    chk("reboot_boot_done", boot_done, 0);
    chk("reboot_words", words_loaded, 0);
    chk("reboot_ready", src_ready, 1);

    // Stalled source, with a reboot during LOAD that must be ignored.
    for (int i = 0; i < 5; i++) begin
      src_valid = vpat[i];
      src_data  = dpat[i];
      src_last  = (i == 4);
      reboot    = (i == 1);
      tick();
      chk("stall_we", imem_we, vpat[i]);
      if (vpat[i]) begin
        chk("stall_addr", imem_addr, apat[i]);
        chk("stall_data", imem_data, dpat[i]);
      end
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
    chk("stall_words", words_loaded, 3);
    // Reboot during HOLD must not disturb release timing.
    reboot = 1'b1;
    for (int i = 1; i <= HC; i++) begin
      tick();
      reboot = 1'b0;
      chk("stall_hold_cpu_reset", cpu_reset, 1);
    end
    tick();
    chk("stall_release", cpu_reset, 0);
    chk("stall_boot_done", boot_done, 1);

    // Overflow: 5 words without last into a 4-word memory.
    reboot = 1'b1;
    tick();
    reboot    = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = DW'(16'ha000 + i);
      tick();
      chk("ovf_we", imem_we, 1);
      chk("ovf_addr", imem_addr, i);
      if (i == 2) chk("ovf_err_early", err, 0);
    end
    chk("ovf_err", err, 1);
    chk("ovf_ready", src_ready, 0);
    chk("ovf_cpu_reset", cpu_reset, 1);
    chk("ovf_words", words_loaded, 4);
    src_data = 16'ha004;
    tick();
    chk("ovf_5th_no_we", imem_we, 0);
    chk("ovf_err_stays", err, 1);
    chk("ovf_ready_stays", src_ready, 0);
    chk("ovf_cpu_reset_stays", cpu_reset, 1);
    src_valid = 1'b0;
    reboot    = 1'b1;
    tick();
    reboot = 1'b0;
    chk("ovf_reboot_err", err, 0);
    chk("ovf_reboot_ready", src_ready, 1);
    chk("ovf_reboot_words", words_loaded, 0);

    // Exact fit: 4 words, last on the top address.
    src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data = DW'(16'hb000 + i);
      src_last = (i == 3);
      tick();
      chk("fit_addr", imem_addr, i);
      chk("fit_data", imem_data, 16'hb000 + i);
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
    chk("fit_words", words_loaded, 4);
    chk("fit_err", err, 0);
    chk("fit_ready", src_ready, 0);
    repeat (HC) tick();
    chk("fit_prerelease", cpu_reset, 1);
    tick();
    chk("fit_release", cpu_reset, 0);
    chk("fit_boot_done", boot_done, 1);
    chk("fit_err_run", err, 0);

    // Asynchronous reset mid-load, then a clean 2-word reload.
    reboot = 1'b1;
    tick();
    reboot    = 1'b0;
    src_valid = 1'b1;
    src_data  = 16'hc000;
    tick();
    src_data = 16'hc001;
    tick();
    chk("pre_rst_words", words_loaded, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cpu_reset", cpu_reset, 1);
    chk("async_ready", src_ready, 0);
    chk("async_we", imem_we, 0);
    chk("async_words", words_loaded, 0);
    chk("async_addr", imem_addr, 0);
    tick();
    reset    = 1'b0;
    src_data = 16'hd000;
    tick();
    chk("reload_ready", src_ready, 1);
    chk("reload_no_we", imem_we, 0);
    tick();
    chk("reload_w0_addr", imem_addr, 0);
    chk("reload_w0_data", imem_data, 16'hd000);
    src_data = 16'hd001;
    src_last = 1'b1;
    tick();
    chk("reload_w1_addr", imem_addr, 1);
    chk("reload_w1_data", imem_data, 16'hd001);
    chk("reload_words", words_loaded, 2);
    src_valid = 1'b0;
    src_last  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
